// File: rtl/hram_pkg.sv
// Shared constants and types for the HyperBus responder: CA field positions, FSM states, burst addressing.
package hram_pkg;

    localparam int unsigned CA_W     = 48;
    localparam int unsigned CA_BYTES = 6;
    localparam int unsigned CA_RW    = 47;
    localparam int unsigned CA_AS    = 46;
    localparam int unsigned CA_BT    = 45;
    localparam int unsigned ID0_ADDR = 0;
    localparam int unsigned CR0_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_READ,
        ST_WRITE,
        ST_REGWR
    } state_t;

    // Next word address: linear counts freely, wrapped stays inside the aligned 16-word group
    function automatic logic [31:0] burst_next(input logic [31:0] addr, input logic linear);
        if (linear) begin
            return addr + 32'd1;
        end
        return {addr[31:4], addr[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/hyper_resp_mem.sv
// Word-wide synchronous RAM with per-byte write enables and a one-cycle registered read.
module hyper_resp_mem #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [1:0]    i_we,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we[1]) begin
            r_mem[i_addr][15:8] <= i_wdata[15:8];
        end
        if (i_we[0]) begin
            r_mem[i_addr][7:0] <= i_wdata[7:0];
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/hyper_resp.sv
// HyperBus device-side responder serving word bursts from an internal RAM.
// Define HYPER_RESP_REGS_EN to include the ID0/CR0 register space; otherwise register reads return zero.
module hyper_resp
    import hram_pkg::*;
#(
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned LATENCY   = 6,
    parameter bit          FIXED_2X  = 1'b1,
    parameter logic [15:0] CR0_RESET = 16'h8F1F,
    parameter logic [15:0] ID0_VAL   = 16'h0C81
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hram_cs_l,
    input  logic       hram_ck,
    input  logic       hram_rst_l,
    input  logic [7:0] hram_dq_in,
    output logic [7:0] hram_dq_out,
    output logic       hram_dq_oe_l,
    input  logic       hram_rwds_in,
    output logic       hram_rwds_out,
    output logic       hram_rwds_oe_l,
    output logic       busy
);

    localparam int unsigned LAT_EDGES = 2 * LATENCY * (FIXED_2X ? 2 : 1);
    localparam int unsigned CNT_W     = $clog2(LAT_EDGES + CA_BYTES);

    logic              r_ck, r_ck_d, r_rwds_s;
    logic [7:0]        r_dq_s;
    state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [CA_W-1:0]   r_ca, w_ca_nx, w_ca_shift;
    logic [MEM_AW-1:0] r_addr, w_addr_nx, w_addr_inc, w_ca_addr;
    logic              r_byte, w_byte_nx;
    logic [15:0]       r_word, w_word_nx;
    logic [7:0]        r_wbuf, w_wbuf_nx;
    logic              r_wmask, w_wmask_nx;
    logic [7:0]        r_dq_out, w_dq_out_nx;
    logic              r_dq_oe_l, w_dq_oe_l_nx;
    logic              r_rwds_out, w_rwds_out_nx;
    logic              r_rwds_oe_l, w_rwds_oe_l_nx;
    logic              r_busy;
    logic              w_edge;
    logic [1:0]        w_mem_we;
    logic [15:0]       w_mem_wdata, w_mem_rdata, w_reg_rd, w_src;
    logic              w_reg_we;
    logic [15:0]       w_reg_wdata;
    logic              w_unused_ca;

    assign w_edge      = r_ck ^ r_ck_d;
    assign w_ca_shift  = {r_ca[CA_W-9:0], r_dq_s};
    assign w_ca_addr   = MEM_AW'({w_ca_shift[44:16], w_ca_shift[2:0]});
    assign w_addr_inc  = MEM_AW'(burst_next(32'(r_addr), r_ca[CA_BT]));
    assign w_src       = r_ca[CA_AS] ? w_reg_rd : w_mem_rdata;
    assign w_unused_ca = ^{r_ca, w_ca_shift};

    hyper_resp_mem #(
        .AW(MEM_AW)
    ) u_mem (
        .clk    (clk),
        .i_addr (r_addr),
        .i_we   (w_mem_we),
        .i_wdata(w_mem_wdata),
        .o_rdata(w_mem_rdata)
    );

`ifdef HYPER_RESP_REGS_EN
    logic [15:0] r_cr0;

    // CR0 reloads on either reset source
    always_ff @(posedge clk) begin
        if (reset || !hram_rst_l) begin
            r_cr0 <= CR0_RESET;
        end else if (w_reg_we) begin
            r_cr0 <= w_reg_wdata;
        end
    end

    always_comb begin
        w_reg_rd = 16'h0000;
        if (r_addr == MEM_AW'(ID0_ADDR)) begin
            w_reg_rd = ID0_VAL;
        end else if (r_addr == MEM_AW'(CR0_ADDR)) begin
            w_reg_rd = r_cr0;
        end
    end
`else
    logic w_unused_regs;

    assign w_reg_rd      = 16'h0000;
    assign w_unused_regs = ^{w_reg_we, w_reg_wdata, ID0_VAL, CR0_RESET};
`endif

    // Next-state and next-output logic; a bus abort overrides every state
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_ca_nx        = r_ca;
        w_addr_nx      = r_addr;
        w_byte_nx      = r_byte;
        w_word_nx      = r_word;
        w_wbuf_nx      = r_wbuf;
        w_wmask_nx     = r_wmask;
        w_dq_out_nx    = r_dq_out;
        w_dq_oe_l_nx   = r_dq_oe_l;
        w_rwds_out_nx  = r_rwds_out;
        w_rwds_oe_l_nx = r_rwds_oe_l;
        w_mem_we       = 2'b00;
        w_mem_wdata    = {r_wbuf, r_dq_s};
        w_reg_we       = 1'b0;
        w_reg_wdata    = {r_wbuf, r_dq_s};

        if (hram_cs_l || !hram_rst_l) begin
            w_state_nx     = ST_IDLE;
            w_dq_oe_l_nx   = 1'b1;
            w_rwds_oe_l_nx = 1'b1;
            w_dq_out_nx    = 8'h00;
            w_rwds_out_nx  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx     = ST_CA;
                    w_cnt_nx       = '0;
                    w_byte_nx      = 1'b0;
                    w_dq_oe_l_nx   = 1'b1;
                    w_rwds_out_nx  = FIXED_2X;
                    w_rwds_oe_l_nx = 1'b0;
                end
                ST_CA: begin
                    if (w_edge) begin
                        w_ca_nx = w_ca_shift;
                        if (r_cnt == CNT_W'(CA_BYTES - 1)) begin
                            w_cnt_nx  = '0;
                            w_addr_nx = w_ca_addr;
                            w_byte_nx = 1'b0;
                            if (!w_ca_shift[CA_RW] && w_ca_shift[CA_AS]) begin
                                w_state_nx     = ST_REGWR;
                                w_rwds_oe_l_nx = 1'b1;
                            end else begin
                                w_state_nx = ST_LAT;
                            end
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LAT: begin
                    if (w_edge) begin
                        if (r_cnt == CNT_W'(LAT_EDGES - 1)) begin
                            if (r_ca[CA_RW]) begin
                                w_state_nx     = ST_READ;
                                w_dq_oe_l_nx   = 1'b0;
                                w_rwds_oe_l_nx = 1'b0;
                                w_dq_out_nx    = w_src[15:8];
                                w_rwds_out_nx  = 1'b1;
                                w_word_nx      = w_src;
                                w_addr_nx      = w_addr_inc;
                                w_byte_nx      = 1'b1;
                            end else begin
                                w_state_nx     = ST_WRITE;
                                w_rwds_oe_l_nx = 1'b1;
                                w_byte_nx      = 1'b0;
                            end
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_READ: begin
                    // RAM already holds the next word since r_addr moved one word ahead
                    if (w_edge) begin
                        if (r_byte) begin
                            w_dq_out_nx   = r_word[7:0];
                            w_rwds_out_nx = 1'b0;
                            w_byte_nx     = 1'b0;
                        end else begin
                            w_dq_out_nx   = w_src[15:8];
                            w_rwds_out_nx = 1'b1;
                            w_word_nx     = w_src;
                            w_addr_nx     = w_addr_inc;
                            w_byte_nx     = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_edge) begin
                        if (!r_byte) begin
                            w_wbuf_nx  = r_dq_s;
                            w_wmask_nx = r_rwds_s;
                            w_byte_nx  = 1'b1;
                        end else begin
                            w_mem_we  = {~r_wmask, ~r_rwds_s};
                            w_addr_nx = w_addr_inc;
                            w_byte_nx = 1'b0;
                        end
                    end
                end
                ST_REGWR: begin
                    if (w_edge) begin
                        if (r_cnt == CNT_W'(0)) begin
                            w_wbuf_nx = r_dq_s;
                            w_cnt_nx  = CNT_W'(1);
                        end else if (r_cnt == CNT_W'(1)) begin
                            w_reg_we = (r_addr == MEM_AW'(CR0_ADDR));
                            w_cnt_nx = CNT_W'(2);
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ck        <= 1'b0;
            r_ck_d      <= 1'b0;
            r_dq_s      <= 8'h00;
            r_rwds_s    <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ca        <= '0;
            r_addr      <= '0;
            r_byte      <= 1'b0;
            r_word      <= 16'h0000;
            r_wbuf      <= 8'h00;
            r_wmask     <= 1'b0;
            r_dq_out    <= 8'h00;
            r_dq_oe_l   <= 1'b1;
            r_rwds_out  <= 1'b0;
            r_rwds_oe_l <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_ck        <= hram_ck;
            r_ck_d      <= r_ck;
            r_dq_s      <= hram_dq_in;
            r_rwds_s    <= hram_rwds_in;
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_ca        <= w_ca_nx;
            r_addr      <= w_addr_nx;
            r_byte      <= w_byte_nx;
            r_word      <= w_word_nx;
            r_wbuf      <= w_wbuf_nx;
            r_wmask     <= w_wmask_nx;
            r_dq_out    <= w_dq_out_nx;
            r_dq_oe_l   <= w_dq_oe_l_nx;
            r_rwds_out  <= w_rwds_out_nx;
            r_rwds_oe_l <= w_rwds_oe_l_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
        end
    end

    assign hram_dq_out    = r_dq_out;
    assign hram_dq_oe_l   = r_dq_oe_l;
    assign hram_rwds_out  = r_rwds_out;
    assign hram_rwds_oe_l = r_rwds_oe_l;
    assign busy           = r_busy;

endmodule

// File: tb/tb_hyper_resp.sv
// Bench for hyper_resp: directed HyperBus transactions plus random bursts checked against a word-array model.
module tb_hyper_resp;

    localparam int unsigned AW        = 10;
    localparam int unsigned DEPTH     = 1 << AW;
    localparam int unsigned LATENCY   = 6;
    localparam int unsigned FIXED_2X  = 1;
    localparam int unsigned LAT_EDGES = 2 * LATENCY * (FIXED_2X != 0 ? 2 : 1);
    localparam int unsigned HALF      = 3;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       hram_cs_l    = 1'b1;
    logic       hram_ck      = 1'b0;
    logic       hram_rst_l   = 1'b1;
    logic [7:0] hram_dq_in   = 8'h00;
    logic       hram_rwds_in = 1'b0;
    logic [7:0] hram_dq_out;
    logic       hram_dq_oe_l, hram_rwds_out, hram_rwds_oe_l, busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_mem [DEPTH];
    logic [1:0]  m_val [DEPTH];
    logic [15:0] m_cr0 = 16'h8F1F;

    logic [7:0]  got [32];
    logic [15:0] wd [16];
    logic [1:0]  wm [16];
    logic [31:0] e32;
    logic [15:0] e16;

    always #5 clk = ~clk;

    hyper_resp #(
        .MEM_AW   (AW),
        .LATENCY  (LATENCY),
        .FIXED_2X (1'b1),
        .CR0_RESET(16'h8F1F),
        .ID0_VAL  (16'h0C81)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hram_cs_l     (hram_cs_l),
        .hram_ck       (hram_ck),
        .hram_rst_l    (hram_rst_l),
        .hram_dq_in    (hram_dq_in),
        .hram_dq_out   (hram_dq_out),
        .hram_dq_oe_l  (hram_dq_oe_l),
        .hram_rwds_in  (hram_rwds_in),
        .hram_rwds_out (hram_rwds_out),
        .hram_rwds_oe_l(hram_rwds_oe_l),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle();
        hram_ck = ~hram_ck;
        wait_n(HALF);
    endtask

    function automatic int unsigned maddr(input int unsigned a, input bit lin, input int unsigned i);
        int unsigned b;
        b = a % DEPTH;
        if (lin) return (b + i) % DEPTH;
        return (b & ~32'hF) | ((b + i) & 32'hF);
    endfunction

    function automatic logic [15:0] reg_model(input int unsigned a);
`ifdef HYPER_RESP_REGS_EN
        if (a == 0) return 16'h0C81;
        if (a == 1) return m_cr0;
`endif
        return 16'h0000;
    endfunction

    task automatic send_ca(input bit rd, input bit as, input bit lin, input logic [31:0] addr);
        logic [47:0] ca;
        ca        = '0;
        ca[47]    = rd;
        ca[46]    = as;
        ca[45]    = lin;
        ca[44:16] = addr[31:3];
        ca[2:0]   = addr[2:0];
        hram_rwds_in = 1'b0;
        hram_cs_l    = 1'b0;
        wait_n(2);
        chk("ca_rwds_oe_l", 16'(hram_rwds_oe_l), 16'd0);
        chk("ca_rwds_out", 16'(hram_rwds_out), 16'(FIXED_2X));
        chk("ca_busy", 16'(busy), 16'd1);
        for (int b = 0; b < 6; b++) begin
            hram_dq_in = ca[47 - 8 * b -: 8];
            toggle();
        end
    endtask

    task automatic lat();
        repeat (LAT_EDGES) toggle();
    endtask

    task automatic end_txn();
        hram_cs_l = 1'b1;
        wait_n(1);
        chk("end_dq_oe_l", 16'(hram_dq_oe_l), 16'd1);
        chk("end_rwds_oe_l", 16'(hram_rwds_oe_l), 16'd1);
        chk("end_busy", 16'(busy), 16'd0);
        hram_ck      = 1'b0;
        hram_rwds_in = 1'b0;
        wait_n(4);
    endtask

    task automatic do_write(input logic [31:0] addr, input bit lin, input int n,
                            input logic [15:0] d [16], input logic [1:0] mk [16]);
        int unsigned a;
        send_ca(1'b0, 1'b0, lin, addr);
        lat();
        chk("wr_rwds_oe_l", 16'(hram_rwds_oe_l), 16'd1);
        chk("wr_dq_oe_l", 16'(hram_dq_oe_l), 16'd1);
        for (int w = 0; w < n; w++) begin
            hram_dq_in   = d[w][15:8];
            hram_rwds_in = mk[w][1];
            toggle();
            hram_dq_in   = d[w][7:0];
            hram_rwds_in = mk[w][0];
            toggle();
            a = maddr(addr, lin, w);
            if (!mk[w][1]) begin
                m_mem[a][15:8] = d[w][15:8];
                m_val[a][1]    = 1'b1;
            end
            if (!mk[w][0]) begin
                m_mem[a][7:0] = d[w][7:0];
                m_val[a][0]   = 1'b1;
            end
        end
        end_txn();
    endtask

    // stop != 0 leaves the burst open after that many bytes for abort tests
    task automatic do_read(input logic [31:0] addr, input bit lin, input bit as, input int n,
                           input int stop, output logic [7:0] g [32]);
        int unsigned a;
        int          nb;
        logic [15:0] w;
        logic        v;
        g  = '{default: 8'h00};
        nb = (stop != 0) ? stop : 2 * n;
        send_ca(1'b1, as, lin, addr);
        lat();
        for (int i = 0; i < nb; i++) begin
            if (i > 0) toggle();
            g[i] = hram_dq_out;
            chk("rd_dq_oe_l", 16'(hram_dq_oe_l), 16'd0);
            chk("rd_rwds_oe_l", 16'(hram_rwds_oe_l), 16'd0);
            chk("rd_rwds_out", 16'(hram_rwds_out), (i % 2 == 0) ? 16'd1 : 16'd0);
            a = maddr(addr, lin, i / 2);
            w = as ? reg_model(a) : m_mem[a];
            v = as ? 1'b1 : m_val[a][1 - (i % 2)];
            if (v) chk("rd_data", 16'(hram_dq_out), (i % 2 == 0) ? 16'(w[15:8]) : 16'(w[7:0]));
        end
        if (stop == 0) end_txn();
    endtask

    task automatic do_regwr(input logic [31:0] addr, input logic [15:0] data);
        send_ca(1'b0, 1'b1, 1'b1, addr);
        hram_dq_in = data[15:8];
        toggle();
        hram_dq_in = data[7:0];
        toggle();
        end_txn();
`ifdef HYPER_RESP_REGS_EN
        if (addr == 1) m_cr0 = data;
`endif
    endtask

    initial begin
        int unsigned ra;
        bit          rl;
        int          rn;
        for (int i = 0; i < int'(DEPTH); i++) m_val[i] = 2'b00;
        wd = '{default: 16'h0000};
        wm = '{default: 2'b00};

        wait_n(3);
        chk("rst_dq_oe_l", 16'(hram_dq_oe_l), 16'd1);
        chk("rst_rwds_oe_l", 16'(hram_rwds_oe_l), 16'd1);
        chk("rst_dq_out", 16'(hram_dq_out), 16'd0);
        chk("rst_rwds_out", 16'(hram_rwds_out), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        reset = 1'b0;
        wait_n(2);

        // two-word linear write then read back
        wd[0] = 16'hDEAD; wd[1] = 16'hBEEF;
        do_write(32'h10, 1'b1, 2, wd, wm);
        do_read(32'h10, 1'b1, 1'b0, 2, 0, got);
        e32 = 32'hDEADBEEF;
        chk("deadbeef_hi", {got[0], got[1]}, e32[31:16]);
        chk("deadbeef_lo", {got[2], got[3]}, e32[15:0]);

        // masked low byte keeps old data
        wd[0] = 16'hAAAA;
        do_write(32'h20, 1'b1, 1, wd, wm);
        wd[0] = 16'h1234; wm[0] = 2'b01;
        do_write(32'h20, 1'b1, 1, wd, wm);
        wm[0] = 2'b00;
        do_read(32'h20, 1'b1, 1'b0, 1, 0, got);
        chk("masked", {got[0], got[1]}, 16'h12AA);

        // linear wrap at top of memory
        wd[0] = 16'h3FF3; wd[1] = 16'h0A0A; wd[2] = 16'h0B0B;
        do_write(32'd1023, 1'b1, 3, wd, wm);
        do_read(32'd1023, 1'b1, 1'b0, 3, 0, got);
        chk("lin_w0", {got[0], got[1]}, 16'h3FF3);
        chk("lin_w1", {got[2], got[3]}, 16'h0A0A);
        chk("lin_w2", {got[4], got[5]}, 16'h0B0B);

        // wrapped burst inside 16-word group
        wd[0] = 16'h1E1E; wd[1] = 16'h1F1F;
        do_write(32'h1E, 1'b1, 2, wd, wm);
        do_read(32'h1E, 1'b0, 1'b0, 3, 0, got);
        chk("wrap_w0", {got[0], got[1]}, 16'h1E1E);
        chk("wrap_w1", {got[2], got[3]}, 16'h1F1F);
        chk("wrap_w2", {got[4], got[5]}, 16'hDEAD);

        // CS abort after one write byte
        wd[0] = 16'h5A5A;
        do_write(32'h30, 1'b1, 1, wd, wm);
        send_ca(1'b0, 1'b0, 1'b1, 32'h30);
        lat();
        hram_dq_in = 8'h77;
        toggle();
        end_txn();
        do_read(32'h30, 1'b1, 1'b0, 1, 0, got);
        chk("abort_kept", {got[0], got[1]}, 16'h5A5A);

        // device reset pin mid-read
        do_read(32'h10, 1'b1, 1'b0, 2, 2, got);
        hram_rst_l = 1'b0;
        wait_n(1);
        chk("rstl_dq_oe_l", 16'(hram_dq_oe_l), 16'd1);
        chk("rstl_rwds_oe_l", 16'(hram_rwds_oe_l), 16'd1);
        chk("rstl_busy", 16'(busy), 16'd0);
        hram_cs_l  = 1'b1;
        hram_rst_l = 1'b1;
        hram_ck    = 1'b0;
        m_cr0      = 16'h8F1F;
        wait_n(4);

        // register space
        do_read(32'h0, 1'b1, 1'b1, 1, 0, got);
`ifdef HYPER_RESP_REGS_EN
        e16 = 16'h0C81;
`else
        e16 = 16'h0000;
`endif
        chk("id0", {got[0], got[1]}, e16);
        do_regwr(32'h1, 16'h8FE7);
        do_read(32'h1, 1'b1, 1'b1, 1, 0, got);
`ifdef HYPER_RESP_REGS_EN
        e16 = 16'h8FE7;
`else
        e16 = 16'h0000;
`endif
        chk("cr0_wr", {got[0], got[1]}, e16);

        // system reset mid-read, then a clean read
        do_read(32'h10, 1'b1, 1'b0, 2, 3, got);
        reset = 1'b1;
        wait_n(1);
        chk("mid_rst_dq_oe_l", 16'(hram_dq_oe_l), 16'd1);
        chk("mid_rst_rwds_oe_l", 16'(hram_rwds_oe_l), 16'd1);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        hram_cs_l = 1'b1;
        hram_ck   = 1'b0;
        m_cr0     = 16'h8F1F;
        wait_n(2);
        reset = 1'b0;
        wait_n(3);
        do_read(32'h10, 1'b1, 1'b0, 2, 0, got);
        chk("post_rst_hi", {got[0], got[1]}, e32[31:16]);
        chk("post_rst_lo", {got[2], got[3]}, e32[15:0]);
        do_read(32'h1, 1'b1, 1'b1, 1, 0, got);

        // random write/read pairs, including aliased high address bits
        for (int k = 0; k < 24; k++) begin
            ra = ((k % 3 == 0) ? 32'd1000 : 32'd0) + $urandom_range(0, 47);
            if ($urandom_range(0, 3) == 0) ra = ra | 32'h800;
            rl = 1'($urandom_range(0, 1));
            rn = int'($urandom_range(1, 4));
            for (int w = 0; w < 16; w++) begin
                wd[w] = 16'($urandom);
                wm[w] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            do_write(ra, rl, rn, wd, wm);
            rl = 1'($urandom_range(0, 1));
            rn = int'($urandom_range(1, 4));
            do_read(ra, rl, 1'b0, rn, 0, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
